// File: rtl/ext_reg_pkg.sv
// Shared types for the external-register requester: FSM state encoding,
// the per-access capture record and the ack direction-match helper.
package ext_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } ext_req_state_e;

    // strobe_valid is low when the subword index addressed no external register
    typedef struct packed {
        logic is_wr;
        logic strobe_valid;
    } ext_req_capture_t;

    function automatic logic ext_ack_match(input logic is_wr,
                                           input logic rd_ack,
                                           input logic wr_ack);
        return is_wr ? wr_ack : rd_ack;
    endfunction

endpackage

// File: rtl/ext_reg_timeout_ctr.sv
// Watchdog down-counter for one outstanding external access. Reloaded while
// clear is high, counts while enabled, and reports expiry at terminal count zero.
module ext_reg_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned CW = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] remaining;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            remaining <= CW'(TIMEOUT - 1);
        end else if (enable && (remaining != '0)) begin
            remaining <= remaining - CW'(1);
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/ext_reg_requester.sv
// Initiator side of the external-register handshake: one CPU access in flight,
// one-cycle req strobe, wait for the matching ack, one-cycle CPU response.
// Optional ack watchdog enabled by defining EXT_REG_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | ready; cpu_req captured into the request registers
//  REQ   | one-hot req strobe toward the external register (one cycle)
//  WAIT  | waiting for direction-matching ack (or watchdog expiry)
//  RESP  | one-cycle cpu_rd_ack / cpu_wr_ack with data and error flag
module ext_reg_requester
    import ext_reg_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SUBWORDS = 1,
    parameter int unsigned TIMEOUT  = 16,
    localparam int unsigned SUB_W   = (SUBWORDS > 1) ? $clog2(SUBWORDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_req_is_wr,
    input  logic [SUB_W-1:0]    cpu_subword,
    input  logic [WIDTH-1:0]    cpu_wr_data,
    input  logic [WIDTH-1:0]    cpu_wr_biten,
    output logic                cpu_req_stall,
    output logic                cpu_rd_ack,
    output logic [WIDTH-1:0]    cpu_rd_data,
    output logic                cpu_wr_ack,
    output logic                cpu_err,
    output logic [SUBWORDS-1:0] req,
    output logic                req_is_wr,
    output logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    wr_biten,
    input  logic                rd_ack,
    input  logic [WIDTH-1:0]    rd_data,
    input  logic                wr_ack
);

    ext_req_state_e      state;
    ext_req_capture_t    cap;
    logic [SUBWORDS-1:0] strobe;
    logic                matched;
    logic                expired;

    always_comb begin
        strobe = '0;
        for (int i = 0; i < int'(SUBWORDS); i++) begin
            if (cpu_subword == SUB_W'(i)) begin
                strobe[i] = 1'b1;
            end
        end
    end

    // An access that strobed no register has no responder, so any ack is foreign.
    assign matched = cap.strobe_valid && ext_ack_match(cap.is_wr, rd_ack, wr_ack);

`ifdef EXT_REG_TIMEOUT_EN
    ext_reg_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  ((state == REQ) || (state == WAIT)),
        .expired (expired)
    );
`else
    // No watchdog: WAIT holds until the matching ack; TIMEOUT kept referenced only.
    assign expired = 1'b0 & (TIMEOUT >= 2);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cap           <= '0;
            cpu_req_stall <= 1'b0;
            cpu_rd_ack    <= 1'b0;
            cpu_rd_data   <= '0;
            cpu_wr_ack    <= 1'b0;
            cpu_err       <= 1'b0;
            req           <= '0;
            req_is_wr     <= 1'b0;
            wr_data       <= '0;
            wr_biten      <= '0;
        end else begin
            req         <= '0;
            cpu_rd_ack  <= 1'b0;
            cpu_wr_ack  <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rd_data <= '0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state         <= REQ;
                        cap           <= '{is_wr: cpu_req_is_wr, strobe_valid: |strobe};
                        req           <= strobe;
                        req_is_wr     <= cpu_req_is_wr;
                        wr_data       <= cpu_wr_data;
                        wr_biten      <= cpu_wr_biten;
                        cpu_req_stall <= 1'b1;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // A matching ack in the expiry cycle still completes cleanly.
                    if (matched || expired) begin
                        state       <= RESP;
                        cpu_rd_ack  <= !cap.is_wr;
                        cpu_wr_ack  <= cap.is_wr;
                        cpu_err     <= !matched;
                        cpu_rd_data <= (matched && !cap.is_wr) ? rd_data : '0;
                        req_is_wr   <= 1'b0;
                        wr_data     <= '0;
                        wr_biten    <= '0;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    cpu_req_stall <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
